// File: rtl/chan_err_inj.sv
// chan_err_inj: channel-error injector that XORs selected code symbols with a mask.
// It supports periodic-burst, LFSR-random and LFSR-burst modes, and keeps saturating error statistics.
module chan_err_inj #(
    parameter int W     = 2,
    parameter int N     = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [N-1:0]     cfg_burst_len,
    input  logic [W-1:0]     cfg_mask,
    input  logic [15:0]      cfg_thresh,
    input  logic [15:0]      cfg_seed,
    input  logic             clr_stats,
    input  logic             valid_i,
    input  logic [W-1:0]     sym_i,
    output logic             valid_o,
    output logic [W-1:0]     sym_o,
    output logic [W-1:0]     err_o,
    output logic [CNT_W-1:0] sym_ct,
    output logic [CNT_W-1:0] bit_err_ct
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [N-1:0] pos, rem, rem_nx, bl_m1;
    logic [15:0] lfsr, seed_v, lfsr_src, lfsr_step;
    logic hit, corrupt, burst_corrupt;
    logic [W-1:0] err;
    logic [$clog2(W+1)-1:0] pc;
    logic [CNT_W:0] bit_sum;
    logic [CNT_W-1:0] sym_ct_nx, bit_err_nx;
    assign seed_v    = (cfg_seed == 16'd0) ? 16'd1 : cfg_seed;
    // A clear with a symbol accepted reloads the seed and steps it for that symbol.
    assign lfsr_src  = clr_stats ? seed_v : lfsr;
    assign lfsr_step = {lfsr_src[14:0], lfsr_src[15] ^ lfsr_src[13] ^ lfsr_src[12] ^ lfsr_src[10]};
    assign hit       = lfsr < cfg_thresh;
    assign bl_m1     = (cfg_burst_len == '0) ? '0 : cfg_burst_len - 1'b1;
    always_comb begin
        state_nx      = state;
        rem_nx        = rem;
        burst_corrupt = 1'b0;
        if (cfg_mode != 2'b11) begin
            state_nx = IDLE;
        end else if (state == BURST) begin
            burst_corrupt = 1'b1;
            rem_nx        = rem - 1'b1;
            state_nx      = (rem == N'(1)) ? IDLE : BURST;
        end else if (hit) begin
            burst_corrupt = 1'b1;
            rem_nx        = bl_m1;
            state_nx      = (bl_m1 != '0) ? BURST : IDLE;
        end
    end
    always_comb begin
        corrupt = (cfg_mode == 2'b01) ? (pos != '0 && pos <= cfg_burst_len) :
                  (cfg_mode == 2'b10) ? hit :
                  (cfg_mode == 2'b11) ? burst_corrupt : 1'b0;
        err     = (valid_i && corrupt && !clr_stats) ? cfg_mask : '0;
        pc      = '0;
        for (int i = 0; i < W; i++) pc = pc + $bits(pc)'(err[i]);
        bit_sum    = {1'b0, bit_err_ct} + (CNT_W+1)'(pc);
        bit_err_nx = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        sym_ct_nx  = (&sym_ct) ? sym_ct : sym_ct + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o    <= 1'b0;
            sym_o      <= '0;
            err_o      <= '0;
            sym_ct     <= '0;
            bit_err_ct <= '0;
            pos        <= '0;
            rem        <= '0;
            state      <= IDLE;
            lfsr       <= seed_v;
        end else begin
            valid_o <= valid_i;
            sym_o   <= sym_i ^ err;
            err_o   <= err;
            if (clr_stats) begin
                sym_ct     <= '0;
                bit_err_ct <= '0;
                pos        <= N'(valid_i);
                rem        <= '0;
                state      <= IDLE;
                lfsr       <= valid_i ? lfsr_step : seed_v;
            end else if (valid_i) begin
                sym_ct     <= sym_ct_nx;
                bit_err_ct <= bit_err_nx;
                pos        <= pos + 1'b1;
                rem        <= rem_nx;
                state      <= state_nx;
                lfsr       <= lfsr_step;
            end
        end
    end
endmodule

// File: tb/tb_chan_err_inj.sv
// tb_chan_err_inj: directed and randomized checks of chan_err_inj against a behavioural model.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_chan_err_inj;
    logic clk = 0, rst = 1;
    logic [1:0] cfg_mode = 0, cfg_mask = 0;
    logic [2:0] cfg_burst_len = 0;
    logic [15:0] cfg_thresh = 0, cfg_seed = 1;
    logic clr_stats = 0, valid_i = 0;
    logic [1:0] sym_i = 0;
    logic valid_o, valid4;
    logic [1:0] sym_o, err_o, sym4, err4;
    logic [31:0] sym_ct, bit_err_ct;
    logic [3:0] sym_ct4, bit_err_ct4;
    int n_cmp = 0, n_bad = 0;
    int m_pos, m_left;
    logic [15:0] m_lfsr;
    longint m_sym, m_bits, m_sym4, m_bits4;

    chan_err_inj dut (.clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_burst_len(cfg_burst_len),
        .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh), .cfg_seed(cfg_seed), .clr_stats(clr_stats),
        .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
        .sym_ct(sym_ct), .bit_err_ct(bit_err_ct));
    chan_err_inj #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_burst_len(cfg_burst_len),
        .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh), .cfg_seed(cfg_seed), .clr_stats(clr_stats),
        .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid4), .sym_o(sym4), .err_o(err4),
        .sym_ct(sym_ct4), .bit_err_ct(bit_err_ct4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] seedfix(input logic [15:0] s);
        return (s == 0) ? 16'd1 : s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_left = 0; m_lfsr = seedfix(cfg_seed);
        m_sym = 0; m_bits = 0; m_sym4 = 0; m_bits4 = 0;
    endtask

    // Drive one cycle, advance the model, then check outputs one cycle later.
    task automatic step(input logic v, input logic [1:0] s, input logic c);
        logic [1:0] e;
        bit hit, cor;
        int bl;
        valid_i = v; sym_i = s; clr_stats = c;
        e = 0; cor = 0; bl = int'(cfg_burst_len);
        if (c) begin
            m_pos = 0; m_left = 0; m_lfsr = seedfix(cfg_seed);
            m_sym = 0; m_bits = 0; m_sym4 = 0; m_bits4 = 0;
        end
        if (v) begin
            if (!c) begin
                hit = m_lfsr < cfg_thresh;
                if (cfg_mode == 1) cor = (m_pos >= 1) && (m_pos <= bl);
                else if (cfg_mode == 2) cor = hit;
                else if (cfg_mode == 3) begin
                    if (m_left > 0) begin cor = 1; m_left--; end
                    else if (hit) begin cor = 1; m_left = ((bl == 0) ? 1 : bl) - 1; end
                end
                if (cfg_mode != 3) m_left = 0;
                e = cor ? cfg_mask : 2'b00;
                m_sym  = (m_sym + 1 > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_sym + 1;
                m_bits = (m_bits + $countones(e) > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_bits + $countones(e);
                m_sym4  = (m_sym4 + 1 > 15) ? 15 : m_sym4 + 1;
                m_bits4 = (m_bits4 + $countones(e) > 15) ? 15 : m_bits4 + $countones(e);
            end
            m_pos  = (m_pos + 1) % 8;
            m_lfsr = lfsr_next(m_lfsr);
        end
        @(posedge clk); #1;
        check("valid_o", valid_o, v);
        check("valid4", valid4, v);
        if (v) begin
            check("sym_o", sym_o, s ^ e);
            check("err_o", err_o, e);
            check("sym4", sym4, s ^ e);
            check("err4", err4, e);
        end
        check("sym_ct", sym_ct, m_sym);
        check("bit_err_ct", bit_err_ct, m_bits);
        check("sym_ct4", sym_ct4, m_sym4);
        check("bit_err_ct4", bit_err_ct4, m_bits4);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            valid_i = i[0]; sym_i = 2'b11;
            @(posedge clk); #1;
            check("rst_valid", valid_o, 0);
            check("rst_sym", sym_o, 0);
            check("rst_err", err_o, 0);
            check("rst_symct", sym_ct, 0);
            check("rst_bitct", bit_err_ct, 0);
        end
        rst = 0; model_reset();
        step(0, 2'b10, 0);
        step(1, 2'b10, 0);
        step(1, 2'b01, 0);

        cfg_mode = 1; cfg_burst_len = 2; cfg_mask = 2'b01;
        step(0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0);
            check("per_sym", sym_o, (i % 8 == 1 || i % 8 == 2) ? 1 : 0);
        end
        check("per_symct", sym_ct, 16);
        check("per_bitct", bit_err_ct, 4);

        step(0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0);
            check("gap_sym", sym_o, (i % 8 == 1 || i % 8 == 2) ? 1 : 0);
            step(0, 0, 0);
        end
        check("gap_bitct", bit_err_ct, 4);

        cfg_mode = 2; cfg_mask = 2'b11; cfg_thresh = 0;
        step(0, 0, 1);
        for (int i = 0; i < 100; i++) step(1, 2'($urandom), 0);
        check("thr0_bitct", bit_err_ct, 0);
        cfg_seed = 1; cfg_thresh = 2;
        step(0, 0, 1);
        step(1, 2'b00, 0);
        check("thr2_err", err_o, 2'b11);
        check("thr2_bitct", bit_err_ct, 2);

        cfg_mode = 3; cfg_burst_len = 3;
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            check("rb_err", err_o, (i < 3) ? 2'b11 : 2'b00);
        end
        step(0, 0, 1);
        step(1, 0, 0);
        check("rb_first", err_o, 2'b11);
        step(1, 0, 1);
        check("rb_clr_err", err_o, 0);
        check("rb_clr_ct", sym_ct, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            check("rb_after", err_o, 0);
        end
        check("rb_after_ct", sym_ct, 5);

        cfg_mode = 1; cfg_burst_len = 7; cfg_mask = 2'b11;
        step(0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 2'($urandom), 0);
        check("sat_symct", sym_ct4, 15);
        check("sat_bitct", bit_err_ct4, 15);

        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) begin
                cfg_mode = 2'($urandom); cfg_burst_len = 3'($urandom); cfg_mask = 2'($urandom);
                cfg_thresh = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 600));
                cfg_seed = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            end
            if (i == 200) begin
                rst = 1; #2;
                check("arst_valid", valid_o, 0);
                check("arst_symct", sym_ct, 0);
                @(posedge clk); #1;
                rst = 0; model_reset();
            end
            step(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
